// File: rtl/next_x_step_pkg.sv
// Shared types and constants for the next_x_step engine: FSM states, FP constants, dimensions.
package next_x_step_pkg;

  typedef enum logic [2:0] {StIdle, StMul, StAcc, StDamp, StSub, StOut} state_t;

  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  localparam int unsigned N_X = 3;
  localparam int unsigned N_F = 4;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == FP_EXP_MAX) && (v[22:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [31:0] v);
    return (v[30:23] == FP_EXP_MAX) && (v[22:0] == '0);
  endfunction

endpackage

// File: rtl/adder.sv
// Single-precision adder/subtractor core (s = a + b, or a - b when sub), truncating,
// denormals flushed to zero. The sum is valid in the Lat-th cycle of stable operands.
module adder
  import next_x_step_pkg::*;
#(
  parameter int unsigned Lat = 2
) (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] s
);

  logic [31:0] r;

  always_comb begin
    logic [31:0] bb, big, sml;
    logic [27:0] mb, ms, sum;
    logic [7:0]  sh;
    int          e;
    bb  = b ^ {sub, 31'b0};
    big = a;
    sml = bb;
    mb  = '0;
    ms  = '0;
    sum = '0;
    sh  = '0;
    e   = 0;
    r   = FP_ZERO;
    if (is_nan(a) || is_nan(bb) || (is_inf(a) && is_inf(bb) && a[31] != bb[31])) begin
      r = FP_QNAN;
    end else if (is_inf(a)) begin
      r = a;
    end else if (is_inf(bb)) begin
      r = bb;
    end else if (a[30:23] == 8'h00) begin
      r = (bb[30:23] == 8'h00) ? FP_ZERO : bb;
    end else if (bb[30:23] == 8'h00) begin
      r = a;
    end else begin
      if (a[30:0] < bb[30:0]) begin
        big = bb;
        sml = a;
      end
      sh = big[30:23] - sml[30:23];
      // Hidden bit at [26], three guard bits below the mantissa, carry room at [27].
      mb = {2'b01, big[22:0], 3'b000};
      ms = (sh > 8'd26) ? '0 : ({2'b01, sml[22:0], 3'b000} >> sh);
      e  = int'(big[30:23]);
      if (big[31] == sml[31]) begin
        sum = mb + ms;
        if (sum[27]) begin
          sum = sum >> 1;
          e   = e + 1;
        end
      end else begin
        sum = mb - ms;
        for (int i = 0; i < 26; i++) begin
          if (sum != '0 && !sum[26]) begin
            sum = sum << 1;
            e   = e - 1;
          end
        end
      end
      if (sum == '0)   r = FP_ZERO;
      else if (e >= 255) r = {big[31], FP_EXP_MAX, 23'b0};
      else if (e <= 0)   r = {big[31], 31'b0};
      else               r = {big[31], e[7:0], sum[25:3]};
    end
  end

  if (Lat <= 1) begin : g_comb
    assign s = r;
  end else begin : g_pipe
    logic [31:0] pipe_q [Lat-1];
    always_ff @(posedge clk) begin
      pipe_q[0] <= r;
      for (int i = 1; i < int'(Lat) - 1; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign s = pipe_q[Lat-2];
  end

endmodule

// File: rtl/fp_halve.sv
// Combinational halving of a single-precision value by exponent decrement.
// Zero/denormal and Inf/NaN pass through; the smallest normal exponent collapses to signed zero.
module fp_halve
  import next_x_step_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] y
);

  always_comb begin
    y = a;
    if (a[30:23] == 8'h01) begin
      y = {a[31], 31'b0};
    end else if (a[30:23] != 8'h00 && a[30:23] != FP_EXP_MAX) begin
      y = {a[31], a[30:23] - 8'd1, a[22:0]};
    end
  end

endmodule

// File: rtl/mul.sv
// Single-precision multiplier core, truncating, denormals flushed to zero.
// The product is valid in the Lat-th cycle of stable operands.
module mul
  import next_x_step_pkg::*;
#(
  parameter int unsigned Lat = 2
) (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);

  logic [31:0] r;

  always_comb begin
    logic        sgn;
    logic [47:0] prod;
    int          e;
    sgn  = a[31] ^ b[31];
    prod = '0;
    e    = 0;
    r    = FP_ZERO;
    if (is_nan(a) || is_nan(b)) begin
      r = FP_QNAN;
    end else if ((is_inf(a) && b[30:23] == 8'h00) || (is_inf(b) && a[30:23] == 8'h00)) begin
      r = FP_QNAN;
    end else if (is_inf(a) || is_inf(b)) begin
      r = {sgn, FP_EXP_MAX, 23'b0};
    end else if (a[30:23] == 8'h00 || b[30:23] == 8'h00) begin
      r = {sgn, 31'b0};
    end else begin
      prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e    = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (prod[47]) begin
        prod = prod >> 1;
        e    = e + 1;
      end
      if (e >= 255)    r = {sgn, FP_EXP_MAX, 23'b0};
      else if (e <= 0) r = {sgn, 31'b0};
      else             r = {sgn, e[7:0], prod[45:23]};
    end
  end

  if (Lat <= 1) begin : g_comb
    assign p = r;
  end else begin : g_pipe
    logic [31:0] pipe_q [Lat-1];
    always_ff @(posedge clk) begin
      pipe_q[0] <= r;
      for (int i = 1; i < int'(Lat) - 1; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign p = pipe_q[Lat-2];
  end

endmodule

// File: rtl/next_x_step.sv
// Sequential Newton/Broyden step: next_x = x - invJ*f on one shared mul and one shared adder.
// Optional step halving is enabled by defining NEXT_X_STEP_DAMP_EN.
module next_x_step
  import next_x_step_pkg::*;
#(
  parameter int unsigned CORE_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [383:0] invJ,
  input  logic [127:0] f,
  input  logic [95:0]  x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [95:0]  next_x,
  output logic         nan_flag
);

  state_t      state_q, state_d;
  logic [7:0]  lat_q, lat_d;
  logic [1:0]  row_q, row_d, col_q, col_d;
  logic [31:0] acc_q, acc_d, p_q, p_d;
  logic        out_valid_q, out_valid_d;
  logic        cap_en, nx_we, lat_done;

  logic [31:0] invj_q   [N_X*N_F];
  logic [31:0] f_q      [N_F];
  logic [31:0] x_q      [N_X];
  logic [31:0] next_x_q [N_X];

  logic [31:0] mul_p, add_a, add_b, add_s;
  logic        add_sub;

  mul #(.Lat(CORE_LAT)) u_mul (
    .clk (clk),
    .a   (invj_q[{row_q, col_q}]),
    .b   (f_q[col_q]),
    .p   (mul_p)
  );

  adder #(.Lat(CORE_LAT)) u_adder (
    .clk (clk),
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .s   (add_s)
  );

`ifdef NEXT_X_STEP_DAMP_EN
  logic [31:0] acc_half;
  fp_halve u_halve (
    .a (acc_q),
    .y (acc_half)
  );
`endif

  assign lat_done  = (lat_q == 8'(CORE_LAT - 1));
  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;

  always_comb begin
    add_a   = acc_q;
    add_b   = p_q;
    add_sub = 1'b0;
    if (state_q == StSub) begin
      add_a   = x_q[row_q];
      add_b   = acc_q;
      add_sub = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    row_d       = row_q;
    col_d       = col_q;
    acc_d       = acc_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    cap_en      = 1'b0;
    nx_we       = 1'b0;
    if (state_q == StMul || state_q == StAcc || state_q == StSub) begin
      lat_d = lat_done ? 8'd0 : lat_q + 8'd1;
    end
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          cap_en  = 1'b1;
          row_d   = '0;
          col_d   = '0;
          acc_d   = FP_ZERO;
          lat_d   = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        if (lat_done) begin
          p_d     = mul_p;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (lat_done) begin
          acc_d = add_s;
          if (col_q != 2'd3) begin
            col_d   = col_q + 2'd1;
            state_d = StMul;
          end else begin
`ifdef NEXT_X_STEP_DAMP_EN
            state_d = StDamp;
`else
            state_d = StSub;
`endif
          end
        end
      end
`ifdef NEXT_X_STEP_DAMP_EN
      StDamp: begin
        acc_d   = acc_half;
        state_d = StSub;
      end
`endif
      StSub: begin
        if (lat_done) begin
          nx_we = 1'b1;
          acc_d = FP_ZERO;
          col_d = '0;
          if (row_q != 2'd2) begin
            row_d   = row_q + 2'd1;
            state_d = StMul;
          end else begin
            state_d = StOut;
          end
        end
      end
      StOut: begin
        // out_valid rises one cycle after entering OUT, then waits for the handshake.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      lat_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      acc_q       <= FP_ZERO;
      p_q         <= FP_ZERO;
      out_valid_q <= 1'b0;
      for (int i = 0; i < int'(N_X); i++) next_x_q[i] <= FP_ZERO;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      row_q       <= row_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      if (nx_we) next_x_q[row_q] <= add_s;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_en) begin
      for (int k = 0; k < int'(N_X * N_F); k++) invj_q[k] <= invJ[32*k +: 32];
      for (int j = 0; j < int'(N_F); j++) f_q[j] <= f[32*j +: 32];
      for (int i = 0; i < int'(N_X); i++) x_q[i] <= x[32*i +: 32];
    end
  end

  always_comb begin
    nan_flag = 1'b0;
    next_x   = '0;
    for (int i = 0; i < int'(N_X); i++) begin
      next_x[32*i +: 32] = next_x_q[i];
      if (next_x_q[i][30:23] == FP_EXP_MAX) nan_flag = 1'b1;
    end
  end

endmodule

// File: tb/tb_next_x_step.sv
// Directed self-checking bench for next_x_step (default build, or NEXT_X_STEP_DAMP_EN when defined).
module tb_next_x_step;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [383:0] invJ;
  logic [127:0] f;
  logic [95:0]  x;
  logic         out_valid;
  logic         out_ready;
  logic [95:0]  next_x;
  logic         nan_flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  next_x_step #(.CORE_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .invJ      (invJ),
    .f         (f),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .next_x    (next_x),
    .nan_flag  (nan_flag)
  );

  localparam logic [383:0] IdJ   = {32'h0, 32'h3F800000, 32'h0, 32'h0,
                                    32'h0, 32'h0, 32'h3F800000, 32'h0,
                                    32'h0, 32'h0, 32'h0, 32'h3F800000};
  localparam logic [127:0] IdF   = {32'h40E00000, 32'h3F000000, 32'h3F800000, 32'h40000000};
  localparam logic [95:0]  IdX   = {3{32'h40A00000}};
  localparam logic [383:0] OneJ  = {12{32'h3F800000}};
  localparam logic [127:0] OneF  = {4{32'h3F800000}};
  localparam logic [95:0]  ZeroX = '0;
  localparam logic [127:0] NanF  = {32'h40E00000, 32'h3F000000, 32'h3F800000, 32'h7FC00000};

`ifdef NEXT_X_STEP_DAMP_EN
  localparam int          Lat    = 58;
  localparam logic [95:0] IdExp  = {32'h40980000, 32'h40900000, 32'h40800000};
  localparam logic [95:0] RowExp = {3{32'hC0000000}};
`else
  localparam int          Lat    = 55;
  localparam logic [95:0] IdExp  = {32'h40900000, 32'h40800000, 32'h40400000};
  localparam logic [95:0] RowExp = {3{32'hC0800000}};
`endif

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [383:0] j, input logic [127:0] ff, input logic [95:0] xx);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("start_ready", in_ready, 1);
    invJ     = j;
    f        = ff;
    x        = xx;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Edges counted from the acceptance edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 300);
    check_eq("out_timeout", out_valid, 1);
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("hs_out_valid", out_valid, 0);
    check_eq("hs_in_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [95:0] held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    invJ      = '0;
    f         = '0;
    x         = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_next_x", next_x, 0);
    check_eq("rst_nan", nan_flag, 0);

    // Identity step with latency and busy in_ready
    start(IdJ, IdF, IdX);
    check_eq("busy_in_ready", in_ready, 0);
    wait_out(lat);
    check_eq("id_latency", lat, Lat);
    check_eq("id_next_x", next_x, IdExp);
    check_eq("id_nan", nan_flag, 0);
    check_eq("out_in_ready", in_ready, 0);
    handshake();
    check_eq("id_hold_after_hs", next_x, IdExp);

    // Full row sum, out_ready held high: one-cycle out_valid
    out_ready = 1'b1;
    start(OneJ, OneF, ZeroX);
    wait_out(lat);
    check_eq("row_next_x", next_x, RowExp);
    @(posedge clk);
    #1;
    check_eq("row_valid_1cyc", out_valid, 0);
    check_eq("row_in_ready", in_ready, 1);
    out_ready = 1'b0;

    // Backpressure for 20 cycles
    start(IdJ, IdF, IdX);
    wait_out(lat);
    held = next_x;
    check_eq("bp_first", held, IdExp);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check_eq("bp_next_x", next_x, held);
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_in_ready", in_ready, 0);
    end
    handshake();

    // Inputs changed and in_valid pulsed while busy
    start(IdJ, IdF, IdX);
    repeat (10) @(posedge clk);
    #1;
    invJ     = OneJ;
    f        = OneF;
    x        = ZeroX;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
    check_eq("busy_latency", lat, Lat - 11);
    check_eq("busy_next_x", next_x, IdExp);
    handshake();

    // Reset during row 1 accumulate
    start(IdJ, IdF, IdX);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_next_x", next_x, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    rst = 1'b0;
    start(OneJ, OneF, ZeroX);
    wait_out(lat);
    check_eq("post_rst_latency", lat, Lat);
    check_eq("post_rst_next_x", next_x, RowExp);
    handshake();

    // NaN propagation
    start(IdJ, NanF, IdX);
    wait_out(lat);
    check_eq("nan_flag", nan_flag, 1);
    check_eq("nan_x0_exp", next_x[30:23], 8'hFF);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
